// File: rtl/acc_pkg.sv
// Shared AXI encodings and the memory-master FSM state type for the conv accelerator.
package acc_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rmst_state_e;

endpackage

// File: rtl/rd_burst_master.sv
// AXI4 read master: fetches DATA_NUM beats as INCR bursts and streams them to the loop buffer.
// The AR issuer/FSM and the R tracker share the outstanding-burst counter.
module rd_burst_master
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_NUM        = 64,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  clear,
   output logic                  done,
   output logic                  busy,
   output logic                  err,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic                  valid,
   input  logic                  ready
);

   localparam int BYTES       = DATA_WIDTH / 8;
   localparam int NUM_BURSTS  = DATA_NUM / BURST_LEN;
   localparam int BURST_BYTES = BURST_LEN * BYTES;
   localparam int ARC_W       = $clog2(NUM_BURSTS + 1);
   localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam int BEAT_W      = $clog2(DATA_NUM + 1);

   localparam logic [ARC_W-1:0]  NUM_BURSTS_C = ARC_W'(NUM_BURSTS);
   localparam logic [OUT_W-1:0]  MAX_OUT_C    = OUT_W'(MAX_OUTSTANDING);
   localparam logic [BEAT_W-1:0] LAST_BEAT_C  = BEAT_W'(DATA_NUM - 1);
   localparam logic [7:0]        BURST_END_C  = 8'(BURST_LEN - 1);

   rmst_state_e           state;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] burst_addr;
   logic [ARC_W-1:0]      ar_cnt;
   logic [ARC_W-1:0]      ar_cnt_nx;
   logic [OUT_W-1:0]      outstanding;
   logic [OUT_W-1:0]      out_nx;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [7:0]            burst_beat;
   logic                  start;
   logic                  ar_hs;
   logic                  ar_hold;
   logic                  ar_more;
   logic                  r_hs;
   logic                  r_last_hs;
   logic                  last_beat;

   assign m_axi_arlen   = BURST_END_C;
   assign m_axi_arsize  = 3'($clog2(BYTES));
   assign m_axi_arburst = AXI_BURST_INCR;

   assign start     = (state == ST_IDLE) && req;
   assign ar_hs     = m_axi_arvalid && m_axi_arready;
   assign ar_hold   = m_axi_arvalid && !m_axi_arready;
   assign r_hs      = m_axi_rvalid && m_axi_rready;
   assign r_last_hs = r_hs && m_axi_rlast;
   assign ar_cnt_nx = ar_cnt + ARC_W'(ar_hs);
   assign ar_more   = (ar_cnt_nx < NUM_BURSTS_C) && (out_nx < MAX_OUT_C);
   assign last_beat = (state == ST_RUN) && r_hs && (beat_cnt == LAST_BEAT_C);

   // Address of the next burst to issue, accounting for a handshake this cycle
   assign burst_addr = base + ADDR_WIDTH'(ar_cnt_nx) * ADDR_WIDTH'(BURST_BYTES);

   always_comb begin
      out_nx = outstanding;
      if (ar_hs && !r_last_hs) begin
         out_nx = outstanding + OUT_W'(1);
      end else if (!ar_hs && r_last_hs && (outstanding != '0)) begin
         out_nx = outstanding - OUT_W'(1);
      end
   end

   // Stream side is a pass-through while running; drained beats are swallowed
   always_comb begin
      tdata        = m_axi_rdata;
      valid        = 1'b0;
      m_axi_rready = 1'b0;
      case (state)
         ST_RUN: begin
            valid        = m_axi_rvalid;
            m_axi_rready = ready;
         end
         ST_DRAIN: begin
            m_axi_rready = 1'b1;
         end
         default: begin
            valid        = 1'b0;
            m_axi_rready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         base          <= '0;
         ar_cnt        <= '0;
         outstanding   <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         done        <= 1'b0;
         ar_cnt      <= ar_cnt_nx;
         outstanding <= out_nx;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  base          <= addr;
                  ar_cnt        <= '0;
                  m_axi_araddr  <= addr;
                  m_axi_arvalid <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (clear) begin
                  // An issued AR cannot be withdrawn; let it finish, then drain its data
                  if (!ar_hold) begin
                     m_axi_arvalid <= 1'b0;
                  end
                  if ((outstanding == '0) && !m_axi_arvalid) begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else if (last_beat) begin
                  m_axi_arvalid <= 1'b0;
                  done          <= 1'b1;
                  busy          <= 1'b0;
                  state         <= ST_IDLE;
               end else if (!ar_hold) begin
                  m_axi_arvalid <= ar_more;
                  if (ar_more) begin
                     m_axi_araddr <= burst_addr;
                  end
               end
            end
            ST_DRAIN: begin
               if (!ar_hold) begin
                  m_axi_arvalid <= 1'b0;
               end
               if ((out_nx == '0) && !ar_hold) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               m_axi_arvalid <= 1'b0;
               busy          <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         burst_beat <= '0;
         err        <= 1'b0;
      end else if (start) begin
         beat_cnt   <= '0;
         burst_beat <= '0;
         err        <= 1'b0;
      end else if (r_hs) begin
         if (state == ST_RUN) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
         burst_beat <= m_axi_rlast ? 8'd0 : burst_beat + 8'd1;
         // Errors are flagged but the data still flows to the buffer
         if ((m_axi_rresp != AXI_RESP_OKAY) ||
             (m_axi_rlast && (burst_beat != BURST_END_C))) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rd_burst_master.sv
// Directed bench for rd_burst_master: vector table of full fetches plus hand-written
// sequences for outstanding limit, abort, request-while-busy and asynchronous reset.
module tb_rd_burst_master;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req;
   logic [63:0]   addr;
   logic          clear;
   logic          done;
   logic          busy;
   logic          err;
   logic          arvalid;
   logic          arready;
   logic [63:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          rvalid;
   logic          rready;
   logic [511:0]  rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic [511:0]  tdata;
   logic          valid;
   logic          ready;

   always #5 clk = ~clk;

   rd_burst_master #(
      .DATA_WIDTH     (512),
      .ADDR_WIDTH     (64),
      .DATA_NUM       (64),
      .BURST_LEN      (16),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .addr         (addr),
      .clear        (clear),
      .done         (done),
      .busy         (busy),
      .err          (err),
      .m_axi_arvalid(arvalid),
      .m_axi_arready(arready),
      .m_axi_araddr (araddr),
      .m_axi_arlen  (arlen),
      .m_axi_arsize (arsize),
      .m_axi_arburst(arburst),
      .m_axi_rvalid (rvalid),
      .m_axi_rready (rready),
      .m_axi_rdata  (rdata),
      .m_axi_rresp  (rresp),
      .m_axi_rlast  (rlast),
      .tdata        (tdata),
      .valid        (valid),
      .ready        (ready)
   );

   typedef struct {
      logic [63:0]      addr;
      int               ready_mode;
      int               r_delay;
      int               ar_div;
      int               err_beat;
      logic             exp_err;
      logic [3:0][63:0] exp_ar;
   } vec_t;

   vec_t vecs[5];

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int ready_mode = 0, r_delay = 0, ar_div = 1, err_beat = -1, drain_mode = 0;
   logic [63:0] ar_addr_q[$];
   int ar_cyc_q[$];
   int rq[$];
   int r_beat = 0, r_idx = 0;
   int n_beat, data_bad, last_beat_cyc, done_cnt, done_cyc, rr_bad, attr_bad, stab_bad;
   int first_rlast_cyc, last_rlast_cyc, n_rhs, err_beat_cyc, err_seen_cyc;
   logic busy_at_done;
   logic prev_hold = 1'b0;
   logic [63:0] prev_araddr = '0;

   function automatic logic [511:0] pat(input int i);
      return {16{32'(i) + 32'hC0DE_0000}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_slave();
      rvalid  = (rq.size() > 0) && (cyc >= rq[0]);
      rdata   = pat(r_idx);
      rresp   = (r_idx == err_beat) ? 2'b10 : 2'b00;
      rlast   = (r_beat == 15);
      arready = ((cyc % ar_div) == 0);
      ready   = (drain_mode != 0) ? 1'b0 : (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
   endtask

   // One clock: observe at the falling edge, update the slave model after the rising edge
   task automatic step();
      logic hs_ar, hs_r, hs_s, lst;
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      hs_s  = valid && ready;
      lst   = rlast;
      if (prev_hold && (!arvalid || (araddr != prev_araddr))) stab_bad++;
      prev_hold   = arvalid && !arready;
      prev_araddr = araddr;
      if (hs_ar) begin
         ar_addr_q.push_back(araddr);
         ar_cyc_q.push_back(cyc);
         if ((arlen != 8'd15) || (arsize != 3'd6) || (arburst != 2'b01)) attr_bad++;
      end
      if (hs_s) begin
         if (tdata != pat(n_beat)) data_bad++;
         n_beat++;
         last_beat_cyc = cyc;
      end
      if (hs_r) begin
         n_rhs++;
         if (r_idx == err_beat) err_beat_cyc = cyc;
         if (lst) begin
            if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
            last_rlast_cyc = cyc;
         end
      end
      if (busy) begin
         if (drain_mode != 0) begin
            if (!rready || valid) rr_bad++;
         end else if ((rready != ready) || (valid != rvalid)) begin
            rr_bad++;
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
      if (err && (err_seen_cyc < 0)) err_seen_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (hs_r) begin
         r_idx++;
         if (lst) begin
            r_beat = 0;
            void'(rq.pop_front());
         end else begin
            r_beat++;
         end
      end
      if (hs_ar) rq.push_back(cyc + r_delay);
      drive_slave();
   endtask

   task automatic reset_stats();
      ar_addr_q.delete();
      ar_cyc_q.delete();
      n_beat = 0; data_bad = 0; last_beat_cyc = -1; done_cnt = 0; done_cyc = -1;
      rr_bad = 0; attr_bad = 0; stab_bad = 0; first_rlast_cyc = -1; last_rlast_cyc = -1;
      n_rhs = 0; err_beat_cyc = -100; err_seen_cyc = -1; busy_at_done = 1'b1;
      r_idx = 0; r_beat = 0; prev_hold = 1'b0;
   endtask

   task automatic start(input logic [63:0] a);
      req  = 1'b1;
      addr = a;
      step();
      req  = 1'b0;
      err_seen_cyc = -1;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) step();
      repeat (4) step();
   endtask

   task automatic run_vec(input vec_t v, input int k);
      logic [63:0] got;
      ready_mode = v.ready_mode; r_delay = v.r_delay; ar_div = v.ar_div; err_beat = v.err_beat;
      reset_stats();
      start(v.addr);
      chk($sformatf("v%0d_arvalid_lat", k), arvalid, 1);
      chk($sformatf("v%0d_busy_on", k), busy, 1);
      chk($sformatf("v%0d_err_clr", k), err, 0);
      wait_done(3000);
      chk($sformatf("v%0d_ar_count", k), ar_addr_q.size(), 4);
      for (int j = 0; j < 4; j++) begin
         got = (j < ar_addr_q.size()) ? ar_addr_q[j] : '1;
         chk($sformatf("v%0d_araddr%0d", k, j), got, v.exp_ar[j]);
      end
      chk($sformatf("v%0d_ar_attr", k), attr_bad, 0);
      chk($sformatf("v%0d_ar_stable", k), stab_bad, 0);
      chk($sformatf("v%0d_beats", k), n_beat, 64);
      chk($sformatf("v%0d_data", k), data_bad, 0);
      chk($sformatf("v%0d_stream_ctl", k), rr_bad, 0);
      chk($sformatf("v%0d_done_cnt", k), done_cnt, 1);
      chk($sformatf("v%0d_done_lat", k), done_cyc - last_beat_cyc, 1);
      chk($sformatf("v%0d_busy_at_done", k), busy_at_done, 0);
      chk($sformatf("v%0d_busy_end", k), busy, 0);
      chk($sformatf("v%0d_err", k), err, v.exp_err);
      if (v.exp_err) chk($sformatf("v%0d_err_lat", k), err_seen_cyc - err_beat_cyc, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ar_clear;
      vecs[0] = '{addr: 64'h1000, ready_mode: 0, r_delay: 0, ar_div: 1, err_beat: -1, exp_err: 1'b0,
                  exp_ar: {64'h1C00, 64'h1800, 64'h1400, 64'h1000}};
      vecs[1] = '{addr: 64'h8000, ready_mode: 0, r_delay: 1, ar_div: 1, err_beat: 5, exp_err: 1'b1,
                  exp_ar: {64'h8C00, 64'h8800, 64'h8400, 64'h8000}};
      vecs[2] = '{addr: 64'h2_0000_0400, ready_mode: 1, r_delay: 3, ar_div: 2, err_beat: -1, exp_err: 1'b0,
                  exp_ar: {64'h2_0000_1000, 64'h2_0000_0C00, 64'h2_0000_0800, 64'h2_0000_0400}};
      vecs[3] = '{addr: 64'hFFFF_F000, ready_mode: 1, r_delay: 5, ar_div: 3, err_beat: 63, exp_err: 1'b1,
                  exp_ar: {64'hFFFF_FC00, 64'hFFFF_F800, 64'hFFFF_F400, 64'hFFFF_F000}};
      vecs[4] = '{addr: 64'h0, ready_mode: 0, r_delay: 2, ar_div: 1, err_beat: -1, exp_err: 1'b0,
                  exp_ar: {64'hC00, 64'h800, 64'h400, 64'h0}};

      rst_n = 1'b0; req = 1'b0; addr = '0; clear = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; ready = 1'b0;
      reset_stats();
      repeat (3) step();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_valid_rready", {valid, rready}, 0);
      rst_n = 1'b1;
      repeat (2) step();

      // clear while idle must be ignored
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("idle_clear_busy", busy, 0);

      // vector table: 0, 1 (error), 2 (error must clear), 3 (error on last beat), 4 (clears again)
      for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

      // outstanding limit with slow R channel
      ready_mode = 0; r_delay = 20; ar_div = 1; err_beat = -1;
      reset_stats();
      start(64'h4000);
      wait_done(3000);
      begin
         int pre = 0;
         foreach (ar_cyc_q[i]) if (ar_cyc_q[i] < first_rlast_cyc) pre++;
         chk("ost_pre_rlast_ars", pre, 2);
      end
      chk("ost_third_ar_lat", (ar_cyc_q.size() > 2) ? ar_cyc_q[2] - first_rlast_cyc : -1, 1);
      chk("ost_beats", n_beat, 64);
      chk("ost_done", done_cnt, 1);

      // abort after 20 beats with two bursts in flight
      ready_mode = 0; r_delay = 0; ar_div = 1; err_beat = -1;
      reset_stats();
      start(64'h3000);
      for (int i = 0; i < 500 && n_beat < 20; i++) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      drain_mode = 1;
      chk("abort_valid_low", valid, 0);
      ready = 1'b0;
      n_ar_clear = ar_addr_q.size();
      for (int i = 0; i < 500 && busy; i++) step();
      chk("abort_busy_end", busy, 0);
      chk("abort_busy_lat", cyc - last_rlast_cyc, 1);
      chk("abort_no_new_ar", ar_addr_q.size(), n_ar_clear);
      chk("abort_ar_total", ar_addr_q.size(), 3);
      chk("abort_beats_fwd", n_beat, 21);
      chk("abort_r_drained", n_rhs, 48);
      chk("abort_slave_empty", rq.size(), 0);
      chk("abort_drain_ctl", rr_bad, 0);
      chk("abort_no_done", done_cnt, 0);
      drain_mode = 0;
      repeat (3) step();
      chk("abort_no_late_done", done_cnt, 0);
      run_vec(vecs[0], 10);

      // second request while busy is ignored
      ready_mode = 0; r_delay = 0; ar_div = 1; err_beat = -1;
      reset_stats();
      start(64'h1000);
      for (int i = 0; i < 500 && n_beat < 10; i++) step();
      req = 1'b1;
      addr = 64'h5000;
      step();
      req = 1'b0;
      wait_done(3000);
      chk("rwb_beats", n_beat, 64);
      chk("rwb_data", data_bad, 0);
      chk("rwb_done", done_cnt, 1);
      chk("rwb_ar_count", ar_addr_q.size(), 4);
      chk("rwb_ar3", (ar_addr_q.size() > 3) ? ar_addr_q[3] : '1, 64'h1C00);

      // asynchronous reset in the middle of a fetch
      ready_mode = 0; r_delay = 0; ar_div = 1; err_beat = 5;
      reset_stats();
      start(64'h2000);
      for (int i = 0; i < 500 && n_beat < 30; i++) step();
      chk("mid_pre_err", err, 1);
      chk("mid_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_arvalid", arvalid, 0);
      chk("mid_rst_araddr", araddr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_valid_rready", {valid, rready}, 0);
      rq.delete();
      r_beat = 0; r_idx = 0; prev_hold = 1'b0;
      rvalid = 1'b0; rlast = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      run_vec(vecs[4], 11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
